// File: rtl/sign_accumulator_if.sv
// Bundle of the frame-control, sample and sum handshake signals of
// sign_accumulator.
//   master : the side that drives Start/Length, supplies samples and
//            consumes sums (a testbench or upstream controller)
//   slave  : the accumulator itself
// Handshake rule for both streams: a transfer happens on a rising clock edge
// when valid and ready are both high; valid never depends on ready; the
// sender holds data stable while valid is high and ready is low.
// StateDbg mirrors the accumulator FSM state (0=IDLE, 1=ACCUM, 2=DONE).
interface sign_accumulator_if #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int ACC_BIT_WIDTH   = 16,
  parameter int COUNT_BIT_WIDTH = 8
);
  logic                       Start;
  logic [COUNT_BIT_WIDTH-1:0] Length;
  logic                       InputValid;
  logic [INPUT_BIT_WIDTH-1:0] InputData;
  logic                       InputReady;
  logic                       OutputValid;
  logic                       OutputReady;
  logic [ACC_BIT_WIDTH-1:0]   OutputSum;
  logic                       Overflow;
  logic                       Busy;
  logic [1:0]                 StateDbg;

  modport master (
    output Start, Length, InputValid, InputData, OutputReady,
    input  InputReady, OutputValid, OutputSum, Overflow, Busy, StateDbg
  );

  modport slave (
    input  Start, Length, InputValid, InputData, OutputReady,
    output InputReady, OutputValid, OutputSum, Overflow, Busy, StateDbg
  );
endinterface

// File: rtl/sign_accumulator.sv
// Frame accumulator for signed samples coming from the add/sub stage.
// A frame is started in IDLE with Start; Length samples are then accepted
// and summed into a saturating ACC_BIT_WIDTH accumulator. The sum is then
// offered on the output handshake until the consumer takes it.
// Ports:
//   Clk    : clock, all state changes on the rising edge
//   Rst_n  : asynchronous active-low reset, discards any frame in progress
//   bus    : sign_accumulator_if.slave
//            Start/Length           frame start and length (captured in IDLE)
//            InputValid/InputData   sample stream in, InputReady back
//            OutputValid/OutputSum  frame sum out, OutputReady back
//            Overflow               saturation occurred in this frame
//            Busy                   frame in progress or sum pending
//            StateDbg               FSM state for observation
// ACC_BIT_WIDTH must be at least INPUT_BIT_WIDTH.
module sign_accumulator #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int ACC_BIT_WIDTH   = 16,
  parameter int COUNT_BIT_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  sign_accumulator_if.slave    bus
);
  localparam int IW = INPUT_BIT_WIDTH;
  localparam int AW = ACC_BIT_WIDTH;
  localparam int CW = COUNT_BIT_WIDTH;

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic [AW:0]   sum_wide;
  logic [AW-1:0] sum_sat;
  logic          sum_clamped;

  // Sum in AW+1 bits so the true result is always representable; the top
  // two bits disagree exactly when it falls outside the AW-bit range, and
  // the top bit then tells which way to clamp.
  always_comb begin
    sum_wide    = {acc_q[AW-1], acc_q}
                + {{(AW+1-IW){bus.InputData[IW-1]}}, bus.InputData};
    sum_sat     = sum_wide[AW-1:0];
    sum_clamped = 1'b0;
    if (sum_wide[AW] != sum_wide[AW-1]) begin
      sum_clamped = 1'b1;
      sum_sat     = sum_wide[AW] ? ACC_MIN : ACC_MAX;
    end
  end

  assign accept = (state_q == ACCUM) && bus.InputValid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = bus.Length;
          // An empty frame skips straight to presenting a zero sum.
          state_d = (bus.Length == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        // count is always >= 1 here, so the decrement cannot wrap.
        if (accept) begin
          acc_d   = sum_sat;
          ovf_d   = ovf_q | sum_clamped;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.OutputReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // All outputs are registers or direct decodes of the state register.
  assign bus.InputReady  = (state_q == ACCUM);
  assign bus.OutputValid = (state_q == DONE);
  assign bus.OutputSum   = acc_q;
  assign bus.Overflow    = ovf_q;
  assign bus.Busy        = (state_q != IDLE);
  assign bus.StateDbg    = state_q;
endmodule

// File: tb/tb_sign_accumulator.sv
module tb_sign_accumulator;
  logic clk;
  logic rst_n;

  // dut_a: 8-bit samples into a 16-bit accumulator.
  // dut_b: 8-bit samples into an 8-bit accumulator, to reach saturation.
  sign_accumulator_if #(.INPUT_BIT_WIDTH(8), .ACC_BIT_WIDTH(16), .COUNT_BIT_WIDTH(8)) a ();
  sign_accumulator_if #(.INPUT_BIT_WIDTH(8), .ACC_BIT_WIDTH(8),  .COUNT_BIT_WIDTH(8)) b ();

  sign_accumulator #(.INPUT_BIT_WIDTH(8), .ACC_BIT_WIDTH(16), .COUNT_BIT_WIDTH(8)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .bus(a.slave)
  );
  sign_accumulator #(.INPUT_BIT_WIDTH(8), .ACC_BIT_WIDTH(8), .COUNT_BIT_WIDTH(8)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .bus(b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks, dut_a
  task automatic start_a(input logic [7:0] len);
    a.Start  = 1'b1;
    a.Length = len;
    tick();
    a.Start  = 1'b0;
  endtask

  task automatic feed_a(input logic [7:0] data);
    int n = 0;
    a.InputValid = 1'b1;
    a.InputData  = data;
    while (!a.InputReady && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("feed_a_timeout", 0, 1);
    tick();
    a.InputValid = 1'b0;
  endtask

  task automatic take_a();
    a.OutputReady = 1'b1;
    tick();
    a.OutputReady = 1'b0;
  endtask

  // driver tasks, dut_b
  task automatic start_b(input logic [7:0] len);
    b.Start  = 1'b1;
    b.Length = len;
    tick();
    b.Start  = 1'b0;
  endtask

  task automatic feed_b(input logic [7:0] data);
    int n = 0;
    b.InputValid = 1'b1;
    b.InputData  = data;
    while (!b.InputReady && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("feed_b_timeout", 0, 1);
    tick();
    b.InputValid = 1'b0;
  endtask

  task automatic take_b();
    b.OutputReady = 1'b1;
    tick();
    b.OutputReady = 1'b0;
  endtask

  initial begin
    int        acc_cnt;
    logic [6:0] pat;

    rst_n = 1'b0;
    a.Start = 0; a.Length = 0; a.InputValid = 0; a.InputData = 0; a.OutputReady = 0;
    b.Start = 0; b.Length = 0; b.InputValid = 0; b.InputData = 0; b.OutputReady = 0;
    #12;
    check("rst_in_ready", a.InputReady, 0);
    check("rst_out_valid", a.OutputValid, 0);
    check("rst_sum", a.OutputSum, 0);
    check("rst_ovf", a.Overflow, 0);
    check("rst_busy", a.Busy, 0);
    #11 rst_n = 1'b1;
    tick();

    // 1: basic frame 5 + -2 + 7 = 10
    start_a(8'd3);
    check("t1_busy", a.Busy, 1);
    check("t1_in_ready", a.InputReady, 1);
    feed_a(8'd5);
    feed_a(8'(-2));
    feed_a(8'd7);
    check("t1_valid", a.OutputValid, 1);
    check("t1_sum", a.OutputSum, 16'd10);
    check("t1_ovf", a.Overflow, 0);
    check("t1_in_ready_done", a.InputReady, 0);
    take_a();
    check("t1_valid_after", a.OutputValid, 0);
    check("t1_busy_after", a.Busy, 0);

    // 2: saturation on the 8-bit accumulator
    start_b(8'd2);
    feed_b(8'd100);
    feed_b(8'd100);
    check("t2_valid", b.OutputValid, 1);
    check("t2_sum_max", b.OutputSum, 8'h7F);
    check("t2_ovf", b.Overflow, 1);
    take_b();
    check("t2_ovf_held_idle", b.Overflow, 1);
    start_b(8'd1);
    check("t2_ovf_cleared", b.Overflow, 0);
    feed_b(8'(-128));
    check("t2_sum_min_exact", b.OutputSum, 8'h80);
    check("t2_ovf_none", b.Overflow, 0);
    take_b();
    start_b(8'd2);
    feed_b(8'(-100));
    feed_b(8'(-100));
    check("t2_sum_neg_clamp", b.OutputSum, 8'h80);
    check("t2_ovf_neg", b.Overflow, 1);
    take_b();

    // 3: gapped valid 1,0,0,1,1,0,1 with data 1..7 -> accepts 1,4,5,7 = 17
    start_a(8'd4);
    pat = 7'b1011001;
    acc_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      a.InputValid = pat[i];
      a.InputData  = 8'(i + 1);
      if (a.InputValid && a.InputReady) acc_cnt++;
      tick();
    end
    check("t3_accept_count", acc_cnt, 4);
    check("t3_in_ready_done", a.InputReady, 0);
    check("t3_valid", a.OutputValid, 1);
    check("t3_sum", a.OutputSum, 16'd17);
    a.InputValid = 1'b1;
    a.InputData  = 8'd50;
    tick();
    tick();
    check("t3_sum_not_consumed", a.OutputSum, 16'd17);
    a.InputValid = 1'b0;
    take_a();

    // 4: empty frame, stalled consumer, Start ignored in DONE
    start_a(8'd0);
    check("t4_valid", a.OutputValid, 1);
    check("t4_sum", a.OutputSum, 16'd0);
    for (int i = 0; i < 5; i++) begin
      a.Start  = 1'b1;
      a.Length = 8'd3;
      tick();
      check("t4_valid_stable", a.OutputValid, 1);
      check("t4_sum_stable", a.OutputSum, 16'd0);
      check("t4_state_done", a.StateDbg, 2'd2);
    end
    a.Start = 1'b0;
    take_a();
    check("t4_idle", a.StateDbg, 2'd0);

    // 5: asynchronous reset mid-frame, then a fresh frame
    start_a(8'd5);
    feed_a(8'd9);
    feed_a(8'd9);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", a.InputReady, 0);
    check("t5_rst_busy", a.Busy, 0);
    check("t5_rst_sum", a.OutputSum, 0);
    check("t5_rst_valid", a.OutputValid, 0);
    check("t5_rst_ovf_b", b.Overflow, 0);
    #4 rst_n = 1'b1;
    tick();
    start_a(8'd1);
    feed_a(8'(-3));
    check("t5_sum", a.OutputSum, 16'hFFFD);

    // 6: back-to-back frames accumulate independently
    take_a();
    start_a(8'd2);
    feed_a(8'd50);
    feed_a(8'd60);
    check("t6_sum1", a.OutputSum, 16'd110);
    take_a();
    start_a(8'd2);
    feed_a(8'(-1));
    feed_a(8'(-1));
    check("t6_sum2", a.OutputSum, 16'hFFFE);
    check("t6_ovf2", a.Overflow, 0);
    take_a();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
